// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Queues command bytes from the UART receiver and expands each one into a
//   fixed response string for the UART transmitter: '1' -> "CCNU",
//   '2' -> "PLAC", anything else -> NAK_CHAR (or nothing when NAK_EN=0).
//   Bytes are handed over one at a time with a tx_start/tx_busy handshake.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   tx_busy         transmitter busy
//   tx_data/tx_start  byte to send and its one-cycle request pulse
//   busy            FSM active or commands pending
//   ovf_err         sticky: command dropped, queue full
//   to_err          sticky: transmitter did not acknowledge tx_start
//   err_clr         synchronous clear of both sticky errors
module uart_cmd_responder #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          NAK_EN      = 1'b1,
  parameter logic [7:0]  NAK_CHAR    = 8'h3F,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy,
  output logic       ovf_err,
  output logic       to_err,
  input  logic       err_clr
);

  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  // cnt is 0 in the first WAIT_HI cycle (tx_start + 1), so the last allowed
  // cycle is tx_start + ACK_TIMEOUT - 1 and to_err registers exactly at
  // tx_start + ACK_TIMEOUT.
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 2);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_HI, WAIT_LO, GAP} state_t;
  typedef enum logic [1:0] {SEL_CCNU, SEL_PLAC, SEL_NAK} sel_t;

  // ---------------- command queue ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;
  logic [7:0]    head;

  state_t        state, state_d;
  sel_t          sel, sel_d;
  logic [2:0]    idx, idx_d, len;
  logic [TW-1:0] cnt, cnt_d;
  logic          to_set;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == LOAD);
  assign push  = rx_valid && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- response strings ----------------
  function automatic logic [7:0] char_at(input sel_t s, input logic [1:0] i);
    logic [7:0] c;
    c = NAK_CHAR;
    case (s)
      SEL_CCNU: case (i) 2'd0: c = 8'h43; 2'd1: c = 8'h43; 2'd2: c = 8'h4E; default: c = 8'h55; endcase
      SEL_PLAC: case (i) 2'd0: c = 8'h50; 2'd1: c = 8'h4C; 2'd2: c = 8'h41; default: c = 8'h43; endcase
      default:  c = NAK_CHAR;
    endcase
    return c;
  endfunction

  assign len = (sel == SEL_NAK) ? 3'd1 : 3'd4;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state;
    sel_d   = sel;
    idx_d   = idx;
    cnt_d   = cnt;
    to_set  = 1'b0;
    case (state)
      IDLE: if (!empty && !tx_busy) state_d = LOAD;
      LOAD: begin
        idx_d = '0;
        if (head == 8'h31) begin
          sel_d   = SEL_CCNU;
          state_d = SEND;
        end else if (head == 8'h32) begin
          sel_d   = SEL_PLAC;
          state_d = SEND;
        end else if (NAK_EN) begin
          sel_d   = SEL_NAK;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt == TO_LAST) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          idx_d   = idx + 3'd1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          if (idx == len)    state_d = IDLE;
          else if (!tx_busy) state_d = SEND;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_start/tx_data are loaded on entry to SEND so the registered pulse and
  // byte coincide with the single SEND cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= SEL_CCNU;
      idx      <= '0;
      cnt      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_d;
      sel      <= sel_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      tx_start <= (state_d == SEND);
      if (state_d == SEND) tx_data <= char_at(sel_d, idx_d[1:0]);
    end
  end

  // ---------------- sticky errors (set wins over clear) ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
      to_err  <= 1'b0;
    end else begin
      if (rx_valid && full && !pop) ovf_err <= 1'b1;
      else if (err_clr)             ovf_err <= 1'b0;
      if (to_set)       to_err <= 1'b1;
      else if (err_clr) to_err <= 1'b0;
    end
  end

  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Testbench for uart_cmd_responder: directed command sequences against a
// transmitter model, with an expected-byte queue built from the response
// rules and checked on every tx_start.
module tb_uart_cmd_responder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned TO    = 16;
  localparam int          HOLD  = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       ovf_err;
  logic       to_err;
  logic       err_clr;

  logic [7:0] rx_data2;
  logic       rx_valid2;
  logic       tx_busy2;
  logic [7:0] tx_data2;
  logic       tx_start2;
  logic       busy2;
  logic       ovf_err2;
  logic       to_err2;
  logic       err_clr2;

  always #5 clk = ~clk;

  uart_cmd_responder #(
    .FIFO_DEPTH(DEPTH), .NAK_EN(1'b1), .NAK_CHAR(8'h3F),
    .GAP_CYCLES(GAP), .ACK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .ovf_err(ovf_err), .to_err(to_err), .err_clr(err_clr)
  );

  uart_cmd_responder #(
    .FIFO_DEPTH(DEPTH), .NAK_EN(1'b0), .NAK_CHAR(8'h3F),
    .GAP_CYCLES(GAP), .ACK_TIMEOUT(TO)
  ) dut_nonak (
    .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .tx_busy(tx_busy2), .tx_data(tx_data2), .tx_start(tx_start2),
    .busy(busy2), .ovf_err(ovf_err2), .to_err(to_err2), .err_clr(err_clr2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_starts  = 0;
  int n_starts2 = 0;
  int last_start = 0;
  logic [7:0] exp_q [$];
  logic [7:0] sent_q [$];

  // transmitter model controls
  bit dead  = 1'b0;   // ignore tx_start entirely
  bit stall = 1'b0;   // hold busy high once raised

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response rules: '1' -> CCNU, '2' -> PLAC, other -> '?' or nothing.
  function automatic void add_resp(input logic [7:0] cmd, input bit nak_en);
    if (cmd == 8'h31) begin
      exp_q.push_back(8'h43); exp_q.push_back(8'h43);
      exp_q.push_back(8'h4E); exp_q.push_back(8'h55);
    end else if (cmd == 8'h32) begin
      exp_q.push_back(8'h50); exp_q.push_back(8'h4C);
      exp_q.push_back(8'h41); exp_q.push_back(8'h43);
    end else if (nak_en) begin
      exp_q.push_back(8'h3F);
    end
  endfunction

  function automatic int resp_len(input logic [7:0] cmd, input bit nak_en);
    if (cmd == 8'h31 || cmd == 8'h32) return 4;
    return nak_en ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter: busy rises 2 cycles after tx_start, stays high HOLD cycles.
  initial begin
    int pend;
    int hold;
    pend = 0;
    hold = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0 && !stall) begin
        hold--;
        if (hold == 0) tx_busy = 1'b0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          tx_busy = 1'b1;
          hold = HOLD;
        end
      end
      if (tx_start && !dead) pend = 2;
    end
  end

  // Per-cycle compare process.
  initial begin
    logic       prev_start;
    logic       prev_busy;
    logic [7:0] prev_data;
    int         last_fall;
    bit         fall_valid;
    prev_start = 1'b0;
    prev_busy  = 1'b0;
    prev_data  = 8'h00;
    last_fall  = 0;
    fall_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        fall_valid = 1'b0;
      end else begin
        if (prev_busy && !tx_busy) begin
          last_fall  = cyc;
          fall_valid = 1'b1;
        end
        if (tx_start) begin
          n_starts++;
          last_start = cyc;
          sent_q.push_back(tx_data);
          chk("start_while_tx_busy", tx_busy, 0);
          chk("start_back_to_back", prev_start, 0);
          chk("start_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q.pop_front());
          if (fall_valid) chk("gap_after_busy_fall", (cyc - last_fall) >= int'(GAP + 1), 1);
          fall_valid = 1'b0;
        end else begin
          chk("tx_data_stable", tx_data, prev_data);
        end
        if (tx_start2) n_starts2++;
      end
      prev_start = tx_start;
      prev_busy  = tx_busy;
      prev_data  = tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    for (int i = 0; i < budget && n_starts < target; i++) begin
      @(negedge clk);
      #1;
    end
    chk(name, n_starts >= target, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && (busy || tx_busy); i++) begin
      @(negedge clk);
      #1;
    end
    chk(name, busy, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovf_err"}, ovf_err, 0);
    chk({tag, "_to_err"}, to_err, 0);
  endtask

  initial begin
    int base;
    int k;
    int s;
    int t;
    logic [7:0] ovf_cmds [6];
    ovf_cmds = '{8'h31, 8'h32, 8'h31, 8'h32, 8'h31, 8'h32};

    rst = 1'b1;
    rx_valid = 1'b0;  rx_data = 8'h00;  err_clr = 1'b0;
    rx_valid2 = 1'b0; rx_data2 = 8'h00; err_clr2 = 1'b0; tx_busy2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // '1' -> CCNU, latency and gap
    base = n_starts;
    sent_q.delete();
    add_resp(8'h31, 1'b1);
    k = cyc;
    send_cmd(8'h31);
    wait_starts(base + 1, 10, "ccnu_first_start");
    chk("rx_to_tx_start_latency", last_start - k, 3);
    wait_starts(base + 4, 200, "ccnu_all_starts");
    wait_idle(40, "ccnu_busy_returns_low");
    chk("ccnu_start_count", n_starts - base, 4);
    chk("ccnu_byte0", sent_q[0], 8'h43);
    chk("ccnu_byte1", sent_q[1], 8'h43);
    chk("ccnu_byte2", sent_q[2], 8'h4E);
    chk("ccnu_byte3", sent_q[3], 8'h55);

    // '2' then '1' back to back
    base = n_starts;
    add_resp(8'h32, 1'b1);
    add_resp(8'h31, 1'b1);
    send_cmd(8'h32);
    repeat (4) tick();
    send_cmd(8'h31);
    wait_starts(base + 8, 400, "plac_ccnu_starts");
    wait_idle(40, "plac_ccnu_idle");
    chk("plac_ccnu_start_count", n_starts - base, 8);
    chk("plac_ccnu_queue_drained", exp_q.size(), 0);
    chk("plac_ccnu_ovf_err", ovf_err, 0);
    chk("plac_ccnu_to_err", to_err, 0);

    // unknown command, NAK enabled
    base = n_starts;
    add_resp(8'h7A, 1'b1);
    send_cmd(8'h7A);
    wait_starts(base + 1, 10, "nak_start");
    wait_idle(40, "nak_idle");
    chk("nak_byte", sent_q[sent_q.size() - 1], 8'h3F);
    chk("nak_start_count", n_starts - base, 1);

    // unknown command, NAK disabled
    rx_data2  = 8'h7A;
    rx_valid2 = 1'b1;
    tick();
    rx_valid2 = 1'b0;
    chk("nonak_busy_after_push", busy2, 1);
    repeat (2) tick();
    chk("nonak_busy_dropped", busy2, 0);
    repeat (30) tick();
    chk("nonak_no_start", n_starts2, resp_len(8'h7A, 1'b0));

    // overflow with stalled transmitter
    stall = 1'b1;
    base = n_starts;
    for (int i = 0; i < 6; i++) begin
      if (i < int'(DEPTH) + 1) add_resp(ovf_cmds[i], 1'b1);
      send_cmd(ovf_cmds[i]);
      tick();
    end
    chk("ovf_err_set", ovf_err, 1);
    chk("ovf_busy", busy, 1);
    rx_data  = 8'h31;
    rx_valid = 1'b1;
    err_clr  = 1'b1;
    tick();
    rx_valid = 1'b0;
    err_clr  = 1'b0;
    chk("ovf_set_wins_over_clear", ovf_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ovf_err_cleared", ovf_err, 0);
    stall = 1'b0;
    wait_starts(base + 20, 2000, "ovf_strings_sent");
    wait_idle(40, "ovf_idle");
    chk("ovf_start_count", n_starts - base, 20);
    chk("ovf_queue_drained", exp_q.size(), 0);
    chk("ovf_to_err", to_err, 0);

    // ack timeout, then the next command is still served
    dead = 1'b1;
    base = n_starts;
    exp_q.push_back(8'h43);
    add_resp(8'h32, 1'b1);
    send_cmd(8'h31);
    tick();
    send_cmd(8'h32);
    wait_starts(base + 1, 10, "to_first_start");
    s = last_start;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (to_err) begin
        t = cyc;
        break;
      end
    end
    dead = 1'b0;
    chk("to_err_latency", t - s, TO);
    wait_starts(base + 5, 300, "to_next_cmd_served");
    wait_idle(40, "to_idle");
    chk("to_start_count", n_starts - base, 5);
    chk("to_err_sticky", to_err, 1);

    // reset during WAIT_LO of the second CCNU byte
    base = n_starts;
    add_resp(8'h31, 1'b1);
    send_cmd(8'h31);
    wait_starts(base + 2, 100, "rst_second_start");
    for (int i = 0; i < 10 && !tx_busy; i++) tick();
    repeat (2) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    base = n_starts;
    repeat (60) tick();
    chk("no_start_after_reset", n_starts - base, 0);
    chk("idle_after_reset", busy, 0);
    add_resp(8'h32, 1'b1);
    send_cmd(8'h32);
    wait_starts(base + 4, 200, "post_reset_cmd");
    wait_idle(40, "post_reset_idle");
    chk("post_reset_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
